// File: rtl/zxbus_mch.sv
// Z80 bus slave front end: re-strobes the Z80 controls, walks the FCI mux with a settle delay,
// picks the lowest-index hit channel and runs a req/stb handshake with timeout.
module zxbus_mch #(
  parameter int NCH    = 4,
  parameter int SETTLE = 1,
  parameter int TMO    = 255,
  parameter int TW     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd,
  input  logic             wr,
  input  logic             mrq,
  input  logic             iorq,
  input  logic [7:0]       fci_in,
  output logic [1:0]       fci_sel,
  output logic             fci_dir,
  output logic [15:0]      zaddr,
  output logic [7:0]       zdata_in,
  output logic [7:0]       zdata_out,
  output logic             zxb_rnw,
  output logic             zxb_mni,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   ch_req,
  input  logic [NCH-1:0]   ch_stb,
  input  logic [8*NCH-1:0] ch_rdata,
  output logic             busy,
  output logic             tmo_err
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [2:0]    SETTLE_V = 3'(SETTLE);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_WAL, ST_IDLE, ST_WAH, ST_ADH, ST_DEC, ST_ACC, ST_FIN
  } state_t;

  state_t        state_reg, state_next;
  logic          zmrd_reg, zmwr_reg, ziord_reg, ziowr_reg;
  logic [2:0]    settle_reg, settle_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [SW-1:0] sel_reg, sel_next;
  logic [1:0]    fci_sel_reg, fci_sel_next;
  logic          fci_dir_reg, fci_dir_next;
  logic [15:0]   zaddr_reg, zaddr_next;
  logic [7:0]    zdata_in_reg, zdata_in_next;
  logic [7:0]    zdata_out_reg, zdata_out_next;
  logic          rnw_reg, rnw_next;
  logic          mni_reg, mni_next;
  logic [NCH-1:0] ch_req_reg, ch_req_next;
  logic          tmo_err_reg, tmo_err_next;

  logic          act;
  logic [SW-1:0] en_idx;
  logic [7:0]    rdata_arr [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_rdata
      assign rdata_arr[gi] = ch_rdata[8*gi +: 8];
    end
  endgenerate

  assign act = zmrd_reg | zmwr_reg | ziord_reg | ziowr_reg;

  // Scanning downward leaves the lowest set index as the winner.
  always_comb begin
    en_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_en[i]) en_idx = SW'(i);
    end
  end

  always_comb begin
    state_next     = state_reg;
    settle_next    = settle_reg;
    tmo_next       = tmo_reg;
    sel_next       = sel_reg;
    fci_sel_next   = fci_sel_reg;
    fci_dir_next   = fci_dir_reg;
    zaddr_next     = zaddr_reg;
    zdata_in_next  = zdata_in_reg;
    zdata_out_next = zdata_out_reg;
    rnw_next       = rnw_reg;
    mni_next       = mni_reg;
    ch_req_next    = ch_req_reg;
    tmo_err_next   = 1'b0;
    case (state_reg)
      ST_INIT: begin
        fci_sel_next = 2'd0;
        settle_next  = SETTLE_V;
        state_next   = ST_WAL;
      end
      ST_WAL: begin
        if (settle_reg == 3'd0) state_next = ST_IDLE;
        else                    settle_next = settle_reg - 3'd1;
      end
      ST_IDLE: begin
        zaddr_next[7:0] = fci_in;
        if (act) begin
          rnw_next     = zmrd_reg | ziord_reg;
          mni_next     = zmrd_reg | zmwr_reg;
          fci_sel_next = 2'd1;
          settle_next  = SETTLE_V;
          state_next   = ST_WAH;
        end
      end
      ST_WAH: begin
        if (settle_reg == 3'd0) state_next = ST_ADH;
        else                    settle_next = settle_reg - 3'd1;
      end
      ST_ADH: begin
        zaddr_next[15:8] = fci_in;
        fci_sel_next     = 2'd2;
        settle_next      = SETTLE_V;
        state_next       = ST_DEC;
      end
      ST_DEC: begin
        if (settle_reg != 3'd0) begin
          settle_next = settle_reg - 3'd1;
        end else if (ch_en == '0) begin
          state_next = ST_FIN;
        end else begin
          sel_next    = en_idx;
          ch_req_next = NCH'(1) << en_idx;
          tmo_next    = '0;
          if (rnw_reg) fci_dir_next  = 1'b0;
          else         zdata_in_next = fci_in;
          state_next = ST_ACC;
        end
      end
      ST_ACC: begin
        tmo_next = tmo_reg + TW'(1);
        // A strobe arriving on the expiry cycle still completes the access.
        if (ch_stb[sel_reg]) begin
          ch_req_next = '0;
          if (rnw_reg) zdata_out_next = rdata_arr[sel_reg];
          state_next = ST_FIN;
        end else if (tmo_reg == TMO_LAST) begin
          ch_req_next  = '0;
          tmo_err_next = 1'b1;
          if (rnw_reg) zdata_out_next = 8'hFF;
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        if (!act) begin
          fci_dir_next = 1'b1;
          state_next   = ST_INIT;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_INIT;
      zmrd_reg      <= 1'b0;
      zmwr_reg      <= 1'b0;
      ziord_reg     <= 1'b0;
      ziowr_reg     <= 1'b0;
      settle_reg    <= '0;
      tmo_reg       <= '0;
      sel_reg       <= '0;
      fci_sel_reg   <= 2'd0;
      fci_dir_reg   <= 1'b1;
      zaddr_reg     <= '0;
      zdata_in_reg  <= '0;
      zdata_out_reg <= 8'hFF;
      rnw_reg       <= 1'b0;
      mni_reg       <= 1'b0;
      ch_req_reg    <= '0;
      tmo_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      zmrd_reg      <= mrq & rd;
      zmwr_reg      <= mrq & wr;
      ziord_reg     <= iorq & rd;
      ziowr_reg     <= iorq & wr;
      settle_reg    <= settle_next;
      tmo_reg       <= tmo_next;
      sel_reg       <= sel_next;
      fci_sel_reg   <= fci_sel_next;
      fci_dir_reg   <= fci_dir_next;
      zaddr_reg     <= zaddr_next;
      zdata_in_reg  <= zdata_in_next;
      zdata_out_reg <= zdata_out_next;
      rnw_reg       <= rnw_next;
      mni_reg       <= mni_next;
      ch_req_reg    <= ch_req_next;
      tmo_err_reg   <= tmo_err_next;
    end
  end

  assign fci_sel   = fci_sel_reg;
  assign fci_dir   = fci_dir_reg;
  assign zaddr     = zaddr_reg;
  assign zdata_in  = zdata_in_reg;
  assign zdata_out = zdata_out_reg;
  assign zxb_rnw   = rnw_reg;
  assign zxb_mni   = mni_reg;
  assign ch_req    = ch_req_reg;
  assign tmo_err   = tmo_err_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_zxbus_mch.sv
// Bench for zxbus_mch: event-time model of each bus access checked every cycle,
// plus directed literal checks and a settle-latency comparison across three instances.
module tb_zxbus_mch;
  localparam int NCH = 4;
  localparam int S   = 1;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic rd, wr, mrq, iorq;
  logic [7:0] fci_in;
  logic [NCH-1:0] ch_en, ch_stb;
  logic [8*NCH-1:0] ch_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;

  logic [1:0] a_fci_sel, b_fci_sel, c_fci_sel;
  logic a_fci_dir, b_fci_dir, c_fci_dir;
  logic [15:0] a_zaddr, b_zaddr, c_zaddr;
  logic [7:0] a_zdata_in, b_zdata_in, c_zdata_in;
  logic [7:0] a_zdata_out, b_zdata_out, c_zdata_out;
  logic a_rnw, b_rnw, c_rnw, a_mni, b_mni, c_mni;
  logic [NCH-1:0] a_ch_req, b_ch_req, c_ch_req;
  logic a_busy, b_busy, c_busy, a_tmo_err, b_tmo_err, c_tmo_err;

  zxbus_mch #(.NCH(NCH), .SETTLE(S), .TMO(TMO), .TW(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .rd(rd), .wr(wr), .mrq(mrq), .iorq(iorq),
    .fci_in(fci_in), .fci_sel(a_fci_sel), .fci_dir(a_fci_dir), .zaddr(a_zaddr),
    .zdata_in(a_zdata_in), .zdata_out(a_zdata_out), .zxb_rnw(a_rnw), .zxb_mni(a_mni),
    .ch_en(ch_en), .ch_req(a_ch_req), .ch_stb(ch_stb), .ch_rdata(ch_rdata),
    .busy(a_busy), .tmo_err(a_tmo_err));

  zxbus_mch #(.NCH(NCH), .SETTLE(0), .TMO(TMO), .TW(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .rd(rd), .wr(wr), .mrq(mrq), .iorq(iorq),
    .fci_in(fci_in), .fci_sel(b_fci_sel), .fci_dir(b_fci_dir), .zaddr(b_zaddr),
    .zdata_in(b_zdata_in), .zdata_out(b_zdata_out), .zxb_rnw(b_rnw), .zxb_mni(b_mni),
    .ch_en(ch_en), .ch_req(b_ch_req), .ch_stb(ch_stb), .ch_rdata(ch_rdata),
    .busy(b_busy), .tmo_err(b_tmo_err));

  zxbus_mch #(.NCH(NCH), .SETTLE(3), .TMO(TMO), .TW(8)) dut_c (
    .clk(clk), .reset_n(reset_n), .rd(rd), .wr(wr), .mrq(mrq), .iorq(iorq),
    .fci_in(fci_in), .fci_sel(c_fci_sel), .fci_dir(c_fci_dir), .zaddr(c_zaddr),
    .zdata_in(c_zdata_in), .zdata_out(c_zdata_out), .zxb_rnw(c_rnw), .zxb_mni(c_mni),
    .ch_en(ch_en), .ch_req(c_ch_req), .ch_stb(ch_stb), .ch_rdata(ch_rdata),
    .busy(c_busy), .tmo_err(c_tmo_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External FCI mux as seen by the main instance.
  assign fci_in = (a_fci_sel == 2'd0) ? bus_addr[7:0] :
                  (a_fci_sel == 2'd1) ? bus_addr[15:8] : bus_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // Access model: event times derived from the settle/handshake rules.
  bit m_on = 1'b0;
  int m_P, m_A, m_R, m_E, m_X;
  bit m_hit, m_read, m_tmo;
  logic [3:0] m_onehot;
  logic [15:0] m_addr;
  logic [7:0] m_zhi_old = 8'h00, m_zin_old = 8'h00, m_zout_old = 8'hFF;
  logic [7:0] m_zin_new, m_zout_new;
  bit m_rnw_old = 1'b0, m_mni_old = 1'b0, m_rnw_new, m_mni_new;

  always @(negedge clk) begin
    if (m_on && cyc > m_P) begin
      int c;
      c = cyc;
      chk("busy", a_busy, (c >= m_A) && (c < m_X + S + 2));
      chk("ch_req", a_ch_req, (m_hit && c >= m_R && c < m_E) ? m_onehot : 4'b0);
      chk("tmo_err", a_tmo_err, m_hit && m_tmo && (c == m_E));
      chk("fci_dir", a_fci_dir, !(m_read && m_hit && c >= m_R && c < m_X));
      chk("zdata_out", a_zdata_out, (m_hit && c >= m_E) ? m_zout_new : m_zout_old);
      chk("zdata_in", a_zdata_in, (m_hit && c >= m_R) ? m_zin_new : m_zin_old);
      chk("zaddr", a_zaddr, (c >= m_A + S + 2) ? m_addr : {m_zhi_old, m_addr[7:0]});
      chk("zxb_rnw", a_rnw, (c >= m_A) ? m_rnw_new : m_rnw_old);
      chk("zxb_mni", a_mni, (c >= m_A) ? m_mni_new : m_mni_old);
    end
  end

  task automatic run_txn(input string name, input bit is_mem, input bit is_rd,
                         input logic [15:0] addr, input logic [7:0] data,
                         input logic [3:0] en, input int k, input logic [3:0] stb_mask,
                         input int drop_off, output int lat, output int tmo_pulses,
                         output logic [3:0] req_snap, output logic dir_snap);
    int d, endc, sel;
    bit stb_eff;
    @(posedge clk); #1;
    m_P = cyc;
    m_A = m_P + 2;
    m_R = m_A + 2 * S + 3;
    m_addr = addr;
    m_hit = (en != 4'b0);
    m_read = is_rd;
    m_onehot = en & (~en + 4'd1);
    sel = 0;
    for (int i = NCH - 1; i >= 0; i--) if (en[i]) sel = i;
    stb_eff = (k >= 0) && ((stb_mask & m_onehot) != 4'b0) && (k + 1 <= TMO);
    if (!m_hit) begin
      m_E = m_R; m_tmo = 1'b0;
    end else if (stb_eff) begin
      m_E = m_R + k + 1; m_tmo = 1'b0;
    end else begin
      m_E = m_R + TMO; m_tmo = 1'b1;
    end
    d = m_R + drop_off;
    m_X = (m_E + 1 > d + 2) ? m_E + 1 : d + 2;
    endc = m_X + S + 2;
    m_rnw_new = is_rd;
    m_mni_new = is_mem;
    m_zout_new = (is_rd && m_hit) ? (m_tmo ? 8'hFF : ch_rdata[8*sel +: 8]) : m_zout_old;
    m_zin_new = (!is_rd && m_hit) ? data : m_zin_old;
    bus_addr = addr; bus_data = data; ch_en = en;
    mrq = is_mem; iorq = !is_mem; rd = is_rd; wr = !is_rd;
    m_on = 1'b1;
    lat = -1; tmo_pulses = 0; req_snap = 4'b0; dir_snap = 1'b1;
    while (cyc < endc + 1) begin
      @(posedge clk); #1;
      if (lat < 0 && a_ch_req != 4'b0) lat = cyc - m_A;
      if (a_tmo_err) tmo_pulses++;
      if (cyc == m_R + 1) begin req_snap = a_ch_req; dir_snap = a_fci_dir; end
      ch_stb = (k >= 0 && cyc == m_R + k) ? stb_mask : 4'b0;
      if (cyc == d) {mrq, iorq, rd, wr} = 4'b0;
    end
    m_on = 1'b0;
    m_zhi_old = addr[15:8];
    m_zin_old = m_zin_new;
    m_zout_old = m_zout_new;
    m_rnw_old = m_rnw_new;
    m_mni_old = m_mni_new;
    $display("txn %s: addr=%h rnw=%0d ch_en=%b req_lat=%0d tmo_pulses=%0d zdata_out=%h",
             name, addr, is_rd, en, lat, tmo_pulses, a_zdata_out);
  endtask

  initial begin
    int lat, tp, q, la, lb, lc;
    logic [3:0] rs;
    logic ds;
    reset_n = 1'b0;
    {rd, wr, mrq, iorq} = 4'b0;
    ch_en = 4'b0; ch_stb = 4'b0;
    ch_rdata = {8'hC3, 8'h11, 8'h3C, 8'h77};
    bus_addr = 16'h0000; bus_data = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("rst_fci_sel", a_fci_sel, 2'd0);
    chk("rst_fci_dir", a_fci_dir, 1'b1);
    chk("rst_ch_req", a_ch_req, 4'b0);
    chk("rst_zaddr", a_zaddr, 16'h0000);
    chk("rst_zdata_in", a_zdata_in, 8'h00);
    chk("rst_zdata_out", a_zdata_out, 8'hFF);
    chk("rst_rnw", a_rnw, 1'b0);
    chk("rst_mni", a_mni, 1'b0);
    chk("rst_tmo_err", a_tmo_err, 1'b0);
    chk("rst_busy", a_busy, 1'b1);
    reset_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("idle_busy", a_busy, 1'b0);

    // Memory write to channel 2, strobe three cycles after request.
    run_txn("mem_wr", 1'b1, 1'b0, 16'h5B00, 8'hA5, 4'b0100, 3, 4'b0100, 7, lat, tp, rs, ds);
    chk("t1_lat", lat, 5);
    chk("t1_req", rs, 4'b0100);
    chk("t1_dir", ds, 1'b1);
    chk("t1_zaddr", a_zaddr, 16'h5B00);
    chk("t1_zdata_in", a_zdata_in, 8'hA5);
    chk("t1_mni", a_mni, 1'b1);
    chk("t1_rnw", a_rnw, 1'b0);

    // I/O read, channels 1 and 2 both hit: channel 1 wins.
    run_txn("io_rd", 1'b0, 1'b1, 16'h00FE, 8'h00, 4'b0110, 2, 4'b0010, 5, lat, tp, rs, ds);
    chk("t2_req", rs, 4'b0010);
    chk("t2_dir", ds, 1'b0);
    chk("t2_zaddr", a_zaddr, 16'h00FE);
    chk("t2_zdata_out", a_zdata_out, 8'h3C);
    chk("t2_rnw", a_rnw, 1'b1);
    chk("t2_mni", a_mni, 1'b0);
    chk("t2_dir_end", a_fci_dir, 1'b1);

    // Read with no decoder hit.
    run_txn("miss_rd", 1'b1, 1'b1, 16'h4000, 8'h00, 4'b0000, -1, 4'b0000, 4, lat, tp, rs, ds);
    chk("t3_lat", lat, -1);
    chk("t3_dir", ds, 1'b1);
    chk("t3_zdata_out", a_zdata_out, 8'h3C);

    // Timeout: strobes only on unselected channels, act drops during the handshake.
    run_txn("tmo_rd", 1'b0, 1'b1, 16'h0010, 8'h00, 4'b0001, 2, 4'b1110, 3, lat, tp, rs, ds);
    chk("t4a_req", rs, 4'b0001);
    chk("t4a_pulses", tp, 1);
    chk("t4a_zdata_out", a_zdata_out, 8'hFF);

    // Strobe on the expiry cycle wins.
    run_txn("late_stb", 1'b1, 1'b1, 16'hC000, 8'h00, 4'b1000, 15, 4'b1000, 20, lat, tp, rs, ds);
    chk("t4b_pulses", tp, 0);
    chk("t4b_zdata_out", a_zdata_out, 8'hC3);

    // Asynchronous reset in the middle of a handshake.
    @(posedge clk); #1;
    bus_addr = 16'h1234; ch_en = 4'b0100; mrq = 1'b1; rd = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    chk("t5_req_before", a_ch_req, 4'b0100);
    reset_n = 1'b0;
    #1;
    chk("t5_req_async", a_ch_req, 4'b0);
    chk("t5_dir_async", a_fci_dir, 1'b1);
    {mrq, rd} = 2'b0;
    repeat (2) @(posedge clk); #1;
    chk("t5_zdata_out", a_zdata_out, 8'hFF);
    chk("t5_zaddr", a_zaddr, 16'h0000);
    reset_n = 1'b1;
    q = cyc;
    repeat (2) @(posedge clk); #1;
    chk("t5_busy_wal", a_busy, 1'b1);
    @(posedge clk); #1;
    chk("t5_busy_idle", a_busy, 1'b0);
    $display("txn reset_mid_acc: released at cyc %0d", q);

    // Request latency for SETTLE of 1, 0 and 3.
    repeat (10) @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      bus_addr = 16'h8000; bus_data = 8'h5A; ch_en = 4'b1000; ch_stb = 4'b0;
      if (r == 0) begin mrq = 1'b1; rd = 1'b1; end
      else begin iorq = 1'b1; wr = 1'b1; end
      la = -1; lb = -1; lc = -1;
      for (int n = 1; n <= 30; n++) begin
        @(posedge clk); #1;
        if (la < 0 && a_ch_req != 4'b0) la = n - 2;
        if (lb < 0 && b_ch_req != 4'b0) lb = n - 2;
        if (lc < 0 && c_ch_req != 4'b0) lc = n - 2;
      end
      chk("t6_lat_s1", la, 5);
      chk("t6_lat_s0", lb, 3);
      chk("t6_lat_s3", lc, 9);
      $display("txn latency round %0d: s1=%0d s0=%0d s3=%0d", r, la, lb, lc);
      {mrq, iorq, rd, wr} = 4'b0;
      repeat (20) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
